// File: rtl/shared_reg_arbiter_pkg.sv
// shared_reg_pkg: shared types and constants for shared_reg_arbiter.
//   state_t  : arbiter FSM states (LOCKED is only reachable when the
//              design is built with SHARED_REG_LOCK_EN defined)
//   ptr_w()  : width of the priority pointer / owner index for n requesters
//   RST_*    : reset values of the state and the busy flag
package shared_reg_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT  = 2'd1,
    LOCKED = 2'd2
  } state_t;

  // A single requester still needs a one-bit index.
  function automatic int ptr_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  localparam state_t RST_STATE = IDLE;
  localparam logic   RST_BUSY  = 1'b0;

endpackage

// File: rtl/shared_reg_arbiter_if.sv
// shared_reg_arbiter_if: bus between per-agent control logic and the shared
// register arbiter.
//   req   : per-requester write request (level)
//   wdata : write data, slice i is [i*WIDTH +: WIDTH]
//   clr   : synchronous clear of the shared register
//   lock  : ownership hold request (only with SHARED_REG_LOCK_EN)
//   gnt   : one-hot registered grant pulse
//   owner : index of the last granted requester
//   busy  : arbiter in GRANT or LOCKED
//   q/qb  : shared register and its complement
//
// Handshake: req is a level, gnt is a one-cycle pulse that appears the cycle
// after req is sampled high; the write to q happens on the same edge that
// raises gnt. A requester wanting a single write drops req during its gnt
// cycle; a req still high then is rearbitrated on that edge.
//
// Configuration macro: SHARED_REG_LOCK_EN adds the lock signal.
interface shared_reg_arbiter_if
  import shared_reg_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int WIDTH = 1
);
  localparam int PW = ptr_w(N_REQ);

  logic [N_REQ-1:0]       req;
  logic [N_REQ*WIDTH-1:0] wdata;
  logic                   clr;
`ifdef SHARED_REG_LOCK_EN
  logic [N_REQ-1:0]       lock;
`endif
  logic [N_REQ-1:0]       gnt;
  logic [PW-1:0]          owner;
  logic                   busy;
  logic [WIDTH-1:0]       q;
  logic [WIDTH-1:0]       qb;

`ifdef SHARED_REG_LOCK_EN
  modport master (output req, wdata, clr, lock, input gnt, owner, busy, q, qb);
  modport slave  (input req, wdata, clr, lock, output gnt, owner, busy, q, qb);
`else
  modport master (output req, wdata, clr, input gnt, owner, busy, q, qb);
  modport slave  (input req, wdata, clr, output gnt, owner, busy, q, qb);
`endif

endinterface

// File: rtl/shared_reg_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker.
//   req   : request vector
//   ptr   : highest-priority index (must be < N)
//   valid : some request is pending
//   index : first requester in order ptr, ptr+1, ..., N-1, 0, ..., ptr-1
module rr_pick #(
  parameter int N  = 4,
  parameter int PW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic          valid,
  output logic [PW-1:0] index
);

  logic [2*N-1:0] dbl;
  logic [N-1:0]   rot;
  logic [PW:0]    sum;

  always_comb begin
    // Rotating the doubled vector puts req[ptr] at bit 0, so the lowest set
    // bit of rot is the winner's distance from ptr.
    dbl   = {req, req} >> ptr;
    rot   = dbl[N-1:0];
    valid = |rot;
    sum   = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (rot[k]) begin
        sum = (PW+1)'(ptr) + (PW+1)'(k);
        if (sum >= (PW+1)'(N)) sum = sum - (PW+1)'(N);
      end
    end
    index = sum[PW-1:0];
  end

endmodule

// File: rtl/shared_reg_arbiter.sv
// shared_reg_arbiter: round-robin arbiter sharing one q/qb register among
// N_REQ requesters. Each edge at most one requester is granted; its wdata
// slice is loaded into q and a one-cycle gnt pulse is returned. clr zeroes
// q with priority over every request.
//   clk       : rising-edge clock
//   reset     : asynchronous active-high reset
//   bus       : shared_reg_arbiter_if slave modport (req/wdata/clr/[lock] in,
//               gnt/owner/busy/q/qb out)
//   dbg_state : current FSM state
//
// Configuration macro: SHARED_REG_LOCK_EN enables ownership locking. A grant
// to w with lock[w] high enters LOCKED; while lock[owner] stays high only the
// owner can write and the pointer is frozen.
module shared_reg_arbiter
  import shared_reg_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int WIDTH = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  shared_reg_arbiter_if.slave  bus,
  output state_t               dbg_state
);

  localparam int PW = ptr_w(N_REQ);

  state_t             state_q, state_d;
  logic [PW-1:0]      ptr_q, ptr_d;
  logic [PW-1:0]      owner_q, owner_d;
  logic [N_REQ-1:0]   gnt_q, gnt_d;
  logic [WIDTH-1:0]   q_q, q_d;
  logic               pick_valid;
  logic [PW-1:0]      pick_idx;

  rr_pick #(.N(N_REQ), .PW(PW)) u_pick (
    .req   (bus.req),
    .ptr   (ptr_q),
    .valid (pick_valid),
    .index (pick_idx)
  );

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= RST_STATE;
      ptr_q   <= '0;
      owner_q <= '0;
      gnt_q   <= '0;
      q_q     <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      gnt_q   <= gnt_d;
      q_q     <= q_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    gnt_d   = '0;
    q_d     = q_q;
    if (bus.clr) begin
      // Clear leaves ptr and owner alone; requests this cycle are dropped.
      q_d     = '0;
      state_d = IDLE;
    end
`ifdef SHARED_REG_LOCK_EN
    else if (state_q == LOCKED && bus.lock[owner_q]) begin
      // Owner keeps exclusive access; others stall, pointer frozen.
      state_d = LOCKED;
      if (bus.req[owner_q]) begin
        gnt_d[owner_q] = 1'b1;
        q_d            = bus.wdata[int'(owner_q)*WIDTH +: WIDTH];
      end
    end
`endif
    else if (pick_valid) begin
      gnt_d   = N_REQ'(1) << pick_idx;
      q_d     = bus.wdata[int'(pick_idx)*WIDTH +: WIDTH];
      owner_d = pick_idx;
      ptr_d   = (pick_idx == PW'(N_REQ - 1)) ? '0 : pick_idx + 1'b1;
      state_d = GRANT;
`ifdef SHARED_REG_LOCK_EN
      if (bus.lock[pick_idx]) state_d = LOCKED;
`endif
    end else begin
      state_d = IDLE;
    end
  end

  // Outputs
  always_comb begin
    bus.gnt   = gnt_q;
    bus.owner = owner_q;
    bus.q     = q_q;
    bus.qb    = ~q_q;
    bus.busy  = (state_q == GRANT) || (state_q == LOCKED);
    dbg_state = state_q;
  end

endmodule

// File: tb/tb_shared_reg_arbiter.sv
// Bench for shared_reg_arbiter (N_REQ=4, WIDTH=3). A driver applies
// stimulus on the falling edge and pushes the reference model's expected
// outputs; a monitor compares them just after the next rising edge.
module tb_shared_reg_arbiter;
  import shared_reg_pkg::*;

  localparam int N  = 4;
  localparam int W  = 3;
  localparam int PW = 2;
  localparam int EW = N + PW + 1 + 2 * W;

  logic   clk = 1'b0;
  logic   reset = 1'b1;
  state_t dbg_state;

  shared_reg_arbiter_if #(.N_REQ(N), .WIDTH(W)) bus ();

  shared_reg_arbiter #(.N_REQ(N), .WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  // Scoreboard
  logic [EW-1:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;
  int n_pushed = 0;
  int n_popped = 0;

  // Reference model: the register as seen from outside
  int           m_ptr, m_owner;
  logic [N-1:0] m_gnt;
  logic [W-1:0] m_q;
  bit           m_busy, m_locked;

  function automatic logic [EW-1:0] model_out();
    return {m_gnt, PW'(m_owner), m_busy, m_q, ~m_q};
  endfunction

  task automatic model_reset();
    m_ptr = 0; m_owner = 0; m_gnt = '0; m_q = '0; m_busy = 0; m_locked = 0;
  endtask

  task automatic model_step(input bit r, input logic [N-1:0] rq,
                            input logic [N*W-1:0] wd, input bit c,
                            input logic [N-1:0] lk);
    int w;
    if (r) begin
      model_reset();
    end else if (c) begin
      m_q = '0; m_gnt = '0; m_busy = 0; m_locked = 0;
    end else if (m_locked && lk[m_owner]) begin
      m_gnt = '0;
      if (rq[m_owner]) begin
        m_gnt[m_owner] = 1'b1;
        m_q = wd[m_owner*W +: W];
      end
      m_busy = 1;
    end else begin
      w = -1;
      for (int k = 0; k < N; k++)
        if (w < 0 && rq[(m_ptr + k) % N]) w = (m_ptr + k) % N;
      m_gnt = '0;
      if (w >= 0) begin
        m_gnt[w] = 1'b1;
        m_q      = wd[w*W +: W];
        m_owner  = w;
        m_ptr    = (w + 1) % N;
        m_busy   = 1;
        m_locked = lk[w];
      end else begin
        m_busy = 0; m_locked = 0;
      end
    end
  endtask

  task automatic drive(input bit r, input logic [N-1:0] rq,
                       input logic [N*W-1:0] wd, input bit c,
                       input logic [N-1:0] lk);
    @(negedge clk);
    reset     = r;
    bus.req   = rq;
    bus.wdata = wd;
    bus.clr   = c;
`ifdef SHARED_REG_LOCK_EN
    bus.lock  = lk;
`endif
    model_step(r, rq, wd, c, lk);
    exp_q.push_back(model_out());
    n_pushed++;
  endtask

  // Reset raised between edges: outputs must drop without a clock edge.
  task automatic async_reset_check();
    logic [EW-1:0] got, e;
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    e   = model_out();
    got = {bus.gnt, bus.owner, bus.busy, bus.q, bus.qb};
    n_checks++;
    if (got !== e) begin
      n_fail++;
      $display("FAIL async_reset t=%0t got %b expected %b", $time, got, e);
    end
    exp_q.push_back(e);
    n_pushed++;
  endtask

  // Monitor
  always @(posedge clk) begin
    logic [EW-1:0] e, got;
    #1;
    if (exp_q.size() > 0) begin
      e   = exp_q.pop_front();
      got = {bus.gnt, bus.owner, bus.busy, bus.q, bus.qb};
      n_popped++;
      n_checks++;
      if (got !== e) begin
        n_fail++;
        $display("FAIL out t=%0t {gnt,owner,busy,q,qb} got %b expected %b",
                 $time, got, e);
      end
    end
  end

  initial begin
    logic [N-1:0]   rq, lk;
    logic [N*W-1:0] wd;
    bus.req = '0; bus.wdata = '0; bus.clr = 1'b0;
`ifdef SHARED_REG_LOCK_EN
    bus.lock = '0;
`endif
    model_reset();

    // Reset, then idle for 10 cycles
    repeat (3) drive(1, '0, '0, 0, '0);
    repeat (10) drive(0, '0, '0, 0, '0);

    // All requesters held: rotating grants, q follows the granted slice
    for (int i = 0; i < 6; i++) drive(0, 4'b1111, (N*W)'($urandom), 0, '0);
    drive(0, '0, '0, 0, '0);

    // Move ptr to 2, then two requesters below it
    drive(0, 4'b0010, 12'h0a5, 0, '0);
    drive(0, 4'b0011, 12'h0f3, 0, '0);
    drive(0, 4'b0001, 12'h0f3, 0, '0);
    drive(0, '0, '0, 0, '0);

    // Load q via req[2], clear with req[2] pending, then req[2] granted
    drive(0, 4'b0100, 12'h140, 0, '0);
    drive(0, 4'b0100, 12'h1c0, 1, '0);
    drive(0, 4'b0100, 12'h1c0, 0, '0);
    drive(0, '0, '0, 0, '0);

    // Reset in the middle of a burst
    for (int i = 0; i < 3; i++) drive(0, 4'b1111, (N*W)'($urandom), 0, '0);
    async_reset_check();
    drive(1, 4'b1111, 12'hfff, 0, '0);
    drive(0, 4'b1010, 12'h5a5, 0, '0);
    drive(0, '0, '0, 0, '0);

`ifdef SHARED_REG_LOCK_EN
    // ptr -> 1, then req[1] locked against req[0]
    drive(0, 4'b0001, 12'h007, 0, '0);
    for (int i = 0; i < 3; i++) drive(0, 4'b0011, (N*W)'($urandom), 0, 4'b0010);
    drive(0, 4'b0011, 12'h03f, 0, '0);
    drive(0, '0, '0, 0, '0);
`endif

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      rq = N'($urandom);
      wd = (N*W)'($urandom);
      lk = '0;
`ifdef SHARED_REG_LOCK_EN
      lk = ($urandom_range(0, 3) == 0) ? N'($urandom) : '0;
`endif
      drive(($urandom_range(0, 60) == 0), rq, wd, ($urandom_range(0, 9) == 0), lk);
    end
    drive(0, '0, '0, 0, '0);

    repeat (3) @(posedge clk);
    #2;
    n_checks++;
    if (n_popped != n_pushed || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain popped=%0d pushed=%0d left=%0d", n_popped, n_pushed,
               exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
